// File: rtl/dm_pkg.sv
// Debug-module DMI payload types shared by the debug module and anything on its DMI port.
package dm;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_arb_pkg.sv
// Shared types and constants for the two-host DMI arbiter.
package dmi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RESP    = 2'd2,
        DELIVER = 2'd3
    } dmi_arb_state_e;

    typedef logic req_idx_t;

    localparam logic [1:0] DmiRespErr = 2'h2;

endpackage

// File: rtl/dmi_arb_timeout.sv
// Response watchdog for the DMI arbiter: counts cycles spent waiting in RESP and
// remembers (stale flag) that the debug module still owes a response after a timeout.
// Only instantiated when DMI_ARB_TIMEOUT_EN is defined.
module dmi_arb_timeout #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_resp,
    input  logic resp_valid,
    input  logic stale_clear,
    output logic timeout_hit,
    output logic stale
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_reg;
    logic            stale_reg;

    // Fires in the TimeoutCycles-th consecutive RESP cycle without a response.
    assign timeout_hit = in_resp && !resp_valid && (cnt_reg == CntLast);
    assign stale       = stale_reg;

    // Counter runs only in RESP so every entry starts from zero; stale set on timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            stale_reg <= 1'b0;
        end else begin
            if (in_resp && !timeout_hit) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                cnt_reg <= '0;
            end
            if (timeout_hit) begin
                stale_reg <= 1'b1;
            end else if (stale_clear) begin
                stale_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Two-host round-robin arbiter in front of the single debug-module DMI port.
// One transaction in flight at a time; the response is routed back to its owner.
// Optional response watchdog enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            h_req_valid,
    output logic [1:0]            h_req_ready,
    input  dm::dmi_req_t [1:0]    h_req,
    output logic [1:0]            h_resp_valid,
    input  logic [1:0]            h_resp_ready,
    output dm::dmi_resp_t         h_resp,
    output logic                  dm_req_valid,
    input  logic                  dm_req_ready,
    output dm::dmi_req_t          dm_req,
    input  logic                  dm_resp_valid,
    output logic                  dm_resp_ready,
    input  dm::dmi_resp_t         dm_resp
);

    dmi_arb_state_e state_reg, state_next;
    req_idx_t       ptr_reg, ptr_next;
    req_idx_t       owner_reg, owner_next;
    dm::dmi_req_t   dm_req_reg, dm_req_next;
    dm::dmi_resp_t  h_resp_reg, h_resp_next;

    logic           grant_any;
    req_idx_t       grant_idx;
    logic           timeout_hit;
    logic           stale;

`ifdef DMI_ARB_TIMEOUT_EN
    logic stale_clear;

    // A late response is swallowed in IDLE/REQ while the stale flag is set.
    assign stale_clear = stale && dm_resp_valid
                       && ((state_reg == IDLE) || (state_reg == REQ));

    dmi_arb_timeout #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_resp     (state_reg == RESP),
        .resp_valid  (dm_resp_valid),
        .stale_clear (stale_clear),
        .timeout_hit (timeout_hit),
        .stale       (stale)
    );
`else
    assign timeout_hit = 1'b0;
    assign stale       = 1'b0;
`endif

    // Round-robin pick: priority requester first, otherwise the other one.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_reg;
        if (h_req_valid[ptr_reg]) begin
            grant_any = 1'b1;
            grant_idx = ptr_reg;
        end else if (h_req_valid[~ptr_reg]) begin
            grant_any = 1'b1;
            grant_idx = ~ptr_reg;
        end
    end

    // Per-requester handshake outputs; accept is suppressed while reset is held.
    for (genvar gi = 0; gi < 2; gi++) begin : g_host
        assign h_req_ready[gi]  = rst_n && (state_reg == IDLE) && grant_any
                                && (grant_idx == req_idx_t'(gi));
        assign h_resp_valid[gi] = (state_reg == DELIVER) && (owner_reg == req_idx_t'(gi));
    end

    // The DM request is held back while a stale response is still outstanding.
    assign dm_req_valid  = (state_reg == REQ) && !stale;
    assign dm_resp_ready = (state_reg == RESP)
                         || (stale && ((state_reg == IDLE) || (state_reg == REQ)));
    assign dm_req        = dm_req_reg;
    assign h_resp        = h_resp_reg;

    // Next-state, payload capture and priority update.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        owner_next  = owner_reg;
        dm_req_next = dm_req_reg;
        h_resp_next = h_resp_reg;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    owner_next  = grant_idx;
                    dm_req_next = h_req[grant_idx];
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (dm_req_valid && dm_req_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (dm_resp_valid) begin
                    h_resp_next = dm_resp;
                    state_next  = DELIVER;
                end else if (timeout_hit) begin
                    h_resp_next = '{data: 32'h0, resp: DmiRespErr};
                    state_next  = DELIVER;
                end
            end
            DELIVER: begin
                if (h_resp_ready[owner_reg]) begin
                    ptr_next   = ~owner_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= 1'b0;
            owner_reg  <= 1'b0;
            dm_req_reg <= '0;
            h_resp_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            dm_req_reg <= dm_req_next;
            h_resp_reg <= h_resp_next;
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed self-checking bench for dmi_arbiter. Inputs driven and outputs sampled
// around the falling clock edge. Watchdog checks follow DMI_ARB_TIMEOUT_EN.
module tb_dmi_arbiter;
    import dmi_arb_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         h_req_valid;
    logic [1:0]         h_req_ready;
    dm::dmi_req_t [1:0] h_req;
    logic [1:0]         h_resp_valid;
    logic [1:0]         h_resp_ready;
    dm::dmi_resp_t      h_resp;
    logic               dm_req_valid;
    logic               dm_req_ready;
    dm::dmi_req_t       dm_req;
    logic               dm_resp_valid;
    logic               dm_resp_ready;
    dm::dmi_resp_t      dm_resp;

    int checks = 0;
    int errors = 0;

    dm::dmi_req_t hreq [2][12];
    int           hcnt [2];
    int           hidx [2];

    always #5 clk = ~clk;

    dmi_arbiter #(
        .TimeoutCycles (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .h_req_valid   (h_req_valid),
        .h_req_ready   (h_req_ready),
        .h_req         (h_req),
        .h_resp_valid  (h_resp_valid),
        .h_resp_ready  (h_resp_ready),
        .h_resp        (h_resp),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req        (dm_req),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_ready (dm_resp_ready),
        .dm_resp       (dm_resp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present each host's current queued request, if any.
    task automatic drive_hosts();
        for (int i = 0; i < 2; i++) begin
            h_req_valid[i] = (hidx[i] < hcnt[i]);
            h_req[i]       = (hidx[i] < hcnt[i]) ? hreq[i][hidx[i]] : '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h_req_ready"},   h_req_ready, 0);
        check({tag, "_h_resp_valid"},  h_resp_valid, 0);
        check({tag, "_dm_req_valid"},  dm_req_valid, 0);
        check({tag, "_dm_resp_ready"}, dm_resp_ready, 0);
        check({tag, "_dm_req"},        dm_req, 0);
        check({tag, "_h_resp"},        h_resp, 0);
    endtask

    // One full transaction, called at a falling edge. Optional stalls on DM ready and
    // host response ready; abort returns in the first RESP cycle without responding.
    task automatic txn(input int exp_g, input logic [31:0] rdata, input logic [1:0] rresp,
                       input int req_stall, input int resp_stall, input bit abort);
        int            waited = 0;
        dm::dmi_req_t  exp_req;
        dm::dmi_resp_t exp_resp;
        drive_hosts();
        #1;
        while (h_req_ready == 2'b00 && waited < 20) begin
            @(negedge clk);
            drive_hosts();
            #1;
            waited++;
        end
        if (h_req_ready == 2'b00) begin
            check("grant_wait", 0, 1);
            return;
        end
        check("grant", h_req_ready, 1 << exp_g);
        exp_req = hreq[exp_g][hidx[exp_g]];
        @(posedge clk);
        hidx[exp_g]++;
        @(negedge clk);
        drive_hosts();
        #1;
        for (int k = 0; k < req_stall; k++) begin
            check("stall_dm_req", dm_req, exp_req);
            check("stall_no_grant", h_req_ready, 0);
            @(negedge clk);
            drive_hosts();
            #1;
        end
        check("dm_req_valid", dm_req_valid, 1);
        check("dm_req", dm_req, exp_req);
        dm_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dm_req_ready = 1'b0;
        drive_hosts();
        #1;
        check("dm_resp_ready", dm_resp_ready, 1);
        if (abort) return;
        dm_resp_valid = 1'b1;
        dm_resp       = '{data: rdata, resp: rresp};
        exp_resp      = '{data: rdata, resp: rresp};
        @(posedge clk);
        @(negedge clk);
        dm_resp_valid = 1'b0;
        dm_resp       = '0;
        drive_hosts();
        #1;
        for (int k = 0; k < resp_stall; k++) begin
            check("stall_h_resp", h_resp, exp_resp);
            check("stall_resp_valid", h_resp_valid, 1 << exp_g);
            check("stall_no_grant2", h_req_ready, 0);
            @(negedge clk);
            drive_hosts();
            #1;
        end
        check("resp_route", h_resp_valid, 1 << exp_g);
        check("resp_data", h_resp, exp_resp);
        h_resp_ready        = 2'b00;
        h_resp_ready[exp_g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        h_resp_ready = 2'b00;
    endtask

    initial begin
        int seen;
        int n;
        rst_n         = 1'b0;
        h_req_valid   = '0;
        h_req         = '0;
        h_resp_ready  = '0;
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b0;
        dm_resp       = '0;
        hcnt          = '{0, 0};
        hidx          = '{0, 0};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read of DMStatus from host 0
        hreq[0][0] = '{addr: 7'h11, op: 2'd1, data: 32'h0};
        hcnt[0] = 1;
        txn(0, 32'h00400C82, 2'd0, 0, 0, 1'b0);
        $display("txn single_read host0 addr 11 done");

        // Host 1 alone, restores pointer to 0
        hreq[1][0] = '{addr: 7'h04, op: 2'd2, data: 32'h12345678};
        hcnt[1] = 1;
        txn(1, 32'h0, 2'd0, 0, 0, 1'b0);
        $display("txn single_write host1 addr 04 done");

        // Both hosts continuously valid, four requests each
        for (int k = 0; k < 4; k++) begin
            hreq[0][1 + k] = '{addr: 7'(7'h20 + k), op: 2'd1, data: 32'hA000_0000 + k};
            hreq[1][1 + k] = '{addr: 7'(7'h30 + k), op: 2'd2, data: 32'hB000_0000 + k};
        end
        hcnt[0] = 5;
        hcnt[1] = 5;
        for (int t = 0; t < 8; t++) begin
            txn(t % 2, 32'hC0DE_0000 + t, 2'd0, 0, 0, 1'b0);
            $display("txn rr %0d expected host %0d done", t, t % 2);
        end

        // Stalls: DM not ready 5 cycles, host 0 not taking response 7 cycles
        hreq[0][5] = '{addr: 7'h16, op: 2'd1, data: 32'h0};
        hreq[1][5] = '{addr: 7'h17, op: 2'd1, data: 32'h0};
        hcnt[0] = 6;
        hcnt[1] = 6;
        txn(0, 32'hDEAD_BEEF, 2'd0, 5, 7, 1'b0);
        $display("txn stalled host0 done");
        txn(1, 32'h5555_AAAA, 2'd3, 0, 0, 1'b0);
        $display("txn after_stall host1 done");

        // Reset while in RESP: pointer set to 1 first, then abort host 1's transaction
        hreq[0][6] = '{addr: 7'h38, op: 2'd0, data: 32'hFFFF_FFFF};
        hcnt[0] = 7;
        txn(0, 32'h1, 2'd0, 0, 0, 1'b0);
        $display("txn nop host0 done");
        hreq[1][6] = '{addr: 7'h39, op: 2'd1, data: 32'h0};
        hcnt[1] = 7;
        txn(1, 32'h0, 2'd0, 0, 0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("midreset");
        rst_n = 1'b1;
        $display("txn abort host1 by reset done");
        hreq[0][7] = '{addr: 7'h11, op: 2'd1, data: 32'h0};
        hreq[1][7] = '{addr: 7'h10, op: 2'd2, data: 32'h1};
        hcnt[0] = 8;
        hcnt[1] = 8;
        txn(0, 32'h0000_0C82, 2'd0, 0, 0, 1'b0);
        $display("txn post_reset host0 done");
        txn(1, 32'h0, 2'd0, 0, 0, 1'b0);
        $display("txn post_reset write host1 addr 10 done");

`ifdef DMI_ARB_TIMEOUT_EN
        // DM never answers: error response after 16 RESP cycles
        hreq[0][8] = '{addr: 7'h04, op: 2'd1, data: 32'h0};
        hcnt[0] = 9;
        txn(0, 32'h0, 2'd0, 0, 0, 1'b1);
        n = 0;
        while (h_resp_valid == 2'b00 && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("timeout_cycles", n, 16);
        check("timeout_route", h_resp_valid, 2'b01);
        check("timeout_resp", h_resp, {32'h0, 2'h2});
        h_resp_ready = 2'b01;
        @(posedge clk);
        @(negedge clk);
        h_resp_ready = 2'b00;
        #1;
        check("stale_ready_idle", dm_resp_ready, 1);
        $display("txn timeout host0 done");
        // Next transaction: late response swallowed while in REQ
        hreq[1][8] = '{addr: 7'h05, op: 2'd1, data: 32'h0};
        hcnt[1] = 9;
        drive_hosts();
        #1;
        check("stale_grant", h_req_ready, 2'b10);
        @(posedge clk);
        hidx[1]++;
        @(negedge clk);
        drive_hosts();
        dm_req_ready = 1'b1;
        #1;
        check("stale_ready_req", dm_resp_ready, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("stale_hold_req", dm_resp_ready, 1);
        dm_resp_valid = 1'b1;
        dm_resp       = '{data: 32'h0BAD_0BAD, resp: 2'd0};
        @(posedge clk);
        @(negedge clk);
        dm_resp_valid = 1'b0;
        dm_resp       = '0;
        #1;
        check("stale_cleared_req_valid", dm_req_valid, 1);
        check("stale_cleared_resp_ready", dm_resp_ready, 0);
        @(posedge clk);
        @(negedge clk);
        dm_req_ready = 1'b0;
        #1;
        check("late_in_resp", dm_resp_ready, 1);
        dm_resp_valid = 1'b1;
        dm_resp       = '{data: 32'h0000_600D, resp: 2'd0};
        @(posedge clk);
        @(negedge clk);
        dm_resp_valid = 1'b0;
        dm_resp       = '0;
        #1;
        check("after_stale_route", h_resp_valid, 2'b10);
        check("after_stale_data", h_resp, {32'h0000_600D, 2'h0});
        h_resp_ready = 2'b10;
        @(posedge clk);
        @(negedge clk);
        h_resp_ready = 2'b00;
        $display("txn after_stale host1 done");
`else
        // DM never answers: no response for 1000 cycles
        hreq[0][8] = '{addr: 7'h04, op: 2'd1, data: 32'h0};
        hcnt[0] = 9;
        txn(0, 32'h0, 2'd0, 0, 0, 1'b1);
        seen = 0;
        for (int k = 0; k < 1000; k++) begin
            if (h_resp_valid != 2'b00) seen = 1;
            @(negedge clk);
            #1;
        end
        check("no_timeout_resp", seen, 0);
        check("no_timeout_still_waiting", dm_resp_ready, 1);
        $display("txn no_timeout host0 done");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
